// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cacheline adaptor.
//
// Contents:
//   - Default geometry: 64-bit beats, 4 beats per line, 5 offset bits.
//   - LINE_W : width of one cache line (256 bits).
//   - CNT_W  : width of the beat counter.
//   - FSM state encoding: IDLE, RD_BURST, WR_BURST, DONE.
package cacheline_adaptor_types;

    localparam int BEAT_W_DEF    = 64;
    localparam int BURST_LEN_DEF = 4;
    localparam int OFFSET_W_DEF  = 5;

    localparam int LINE_W = 256;
    localparam int CNT_W  = $clog2(BURST_LEN_DEF);

    localparam int STATE_W = 2;

    // Plain constants rather than an enum so the encoding is visible to
    // older tools and to external checkers that watch dbg_state.
    localparam logic [STATE_W-1:0] IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] RD_BURST = 2'd1;
    localparam logic [STATE_W-1:0] WR_BURST = 2'd2;
    localparam logic [STATE_W-1:0] DONE     = 2'd3;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundle of the cache-side line handshake and the memory-side burst bus.
//
// Cache side (line):
//   line_addr_i, line_read_i, line_write_i, line_wdata_i -> adaptor
//   line_rdata_o, line_resp_o                            <- adaptor
// Memory side (burst):
//   burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o <- adaptor
//   burst_rdata_i, burst_resp_i                              -> adaptor
//
// Handshake: line_read_i/line_write_i stay high until the single-cycle
// line_resp_o pulse; burst_read_o/burst_write_o stay high for the whole
// burst and exactly one beat moves on every cycle burst_resp_i is high.
//
// Modports: slave = the adaptor itself; master = its environment
// (cache plus main memory).
interface cacheline_adaptor_if
    import cacheline_adaptor_types::*;
#(
    parameter int BEAT_W = BEAT_W_DEF
);
    logic [31:0]       line_addr_i;
    logic              line_read_i;
    logic              line_write_i;
    logic [LINE_W-1:0] line_wdata_i;
    logic [LINE_W-1:0] line_rdata_o;
    logic              line_resp_o;

    logic [31:0]       burst_addr_o;
    logic              burst_read_o;
    logic              burst_write_o;
    logic [BEAT_W-1:0] burst_wdata_o;
    logic [BEAT_W-1:0] burst_rdata_i;
    logic              burst_resp_i;

    modport slave (
        input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
        output line_rdata_o, line_resp_o,
        output burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
        input  burst_rdata_i, burst_resp_i
    );

    modport master (
        output line_addr_i, line_read_i, line_write_i, line_wdata_i,
        input  line_rdata_o, line_resp_o,
        input  burst_addr_o, burst_read_o, burst_write_o, burst_wdata_o,
        output burst_rdata_i, burst_resp_i
    );

endinterface

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// line_beat_buffer: one cache line of storage, addressable per beat.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset (clears the line)
//   load_en     load the whole line from load_line (takes priority)
//   load_line   full line to load
//   beat_we     write beat_wdata into beat slot beat_idx
//   beat_idx    beat slot for both write and read
//   beat_wdata  beat to write
//   line_q      current line contents
//   beat_rdata  beat slot beat_idx of the current line
module line_beat_buffer
    import cacheline_adaptor_types::*;
#(
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int IDX_W     = $clog2(BURST_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [BEAT_W*BURST_LEN-1:0] load_line,
    input  logic                        beat_we,
    input  logic [IDX_W-1:0]            beat_idx,
    input  logic [BEAT_W-1:0]           beat_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] line_q,
    output logic [BEAT_W-1:0]           beat_rdata
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_line;
        end else if (beat_we) begin
            line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_wdata;
        end
    end

    assign beat_rdata = line_q[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one 256-bit cache line read/write into a burst
// of BURST_LEN beats of BEAT_W bits on the main-memory bus, and answers
// the cache with a single line_resp_o pulse.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset (abandons any burst)
//   bus        cacheline_adaptor_if.slave (line side + burst side)
//   dbg_state  current FSM state (IDLE/RD_BURST/WR_BURST/DONE)
//
// Flow: IDLE samples the request and registers the line-aligned address;
// RD_BURST fills the buffer beat by beat; WR_BURST drains a line latched
// in IDLE; DONE pulses line_resp_o and returns to IDLE.
module cacheline_adaptor
    import cacheline_adaptor_types::*;
#(
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int OFFSET_W  = OFFSET_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus,
    output logic [STATE_W-1:0]   dbg_state
);

    localparam int LW    = BEAT_W * BURST_LEN;
    localparam int CW    = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    generate
        if (LW != LINE_W) begin : g_bad_geometry
            $error("cacheline_adaptor: BEAT_W*BURST_LEN must equal 256");
        end
    endgenerate

    logic [STATE_W-1:0] state;
    logic [CW-1:0]      cnt;
    logic [31:0]        addr_q;
    logic [LW-1:0]      rdata_q;

    logic [LW-1:0]      buf_line;
    logic [BEAT_W-1:0]  buf_beat;
    logic [LW-1:0]      merged_line;

    logic               buf_load;
    logic               buf_beat_we;
    logic               beat_strobe;
    logic               last_beat;

    assign beat_strobe = bus.burst_resp_i;
    assign last_beat   = (cnt == LAST_BEAT);
    assign buf_load    = (state == IDLE) && bus.line_write_i;
    assign buf_beat_we = (state == RD_BURST) && beat_strobe;

    line_beat_buffer #(
        .BEAT_W    (BEAT_W),
        .BURST_LEN (BURST_LEN),
        .IDX_W     (CW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (buf_load),
        .load_line  (bus.line_wdata_i),
        .beat_we    (buf_beat_we),
        .beat_idx   (cnt),
        .beat_wdata (bus.burst_rdata_i),
        .line_q     (buf_line),
        .beat_rdata (buf_beat)
    );

    // The final read beat is still on the bus when the line is published,
    // so the visible read line is the buffer with that beat merged in.
    // Keeping a separate copy means a later write (which reuses the
    // buffer) cannot disturb line_rdata_o.
    always_comb begin
        merged_line = buf_line;
        merged_line[cnt*BEAT_W +: BEAT_W] = bus.burst_rdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins if the cache illegally raises both.
                    if (bus.line_write_i) begin
                        addr_q <= {bus.line_addr_i[31:OFFSET_W], OFFSET_W'(0)};
                        cnt    <= '0;
                        state  <= WR_BURST;
                    end else if (bus.line_read_i) begin
                        addr_q <= {bus.line_addr_i[31:OFFSET_W], OFFSET_W'(0)};
                        cnt    <= '0;
                        state  <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (beat_strobe) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            rdata_q <= merged_line;
                            state   <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (beat_strobe) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == IDLE) begin
            assert (!(bus.line_read_i && bus.line_write_i))
                else $warning("cacheline_adaptor: read and write requested together, serving write");
        end
    end

    assign bus.burst_addr_o  = addr_q;
    assign bus.burst_read_o  = (state == RD_BURST);
    assign bus.burst_write_o = (state == WR_BURST);
    assign bus.burst_wdata_o = (state == WR_BURST) ? buf_beat : '0;
    assign bus.line_resp_o   = (state == DONE);
    assign bus.line_rdata_o  = rdata_q;
    assign dbg_state         = state;

endmodule
